fifo_stream_reader: RTL

- Read-side master for fifo_sync: drains the FIFO through its rd_en/data_rd/empty interface and presents pixels as a valid/ready stream to the next pipeline stage.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer, so it sustains 1 pixel/clk under continuous m_ready.
- Optionally tags the stream with start-of-frame and end-of-line markers for the downstream image-processing stages.

---
 rtl/fifo_stream_reader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains fifo_sync (rd_en/data_rd/empty) into a valid/ready pixel stream; optional SOF/EOL tags under `FRAME_MARKERS_EN`.
// Latency: m_data valid 2 cycles after fifo_rd_en rises (read edge + capture edge); sustains 1 pixel/clk with m_ready held high.
// Backpressure: m_ready low freezes m_data/m_sof/m_eol; reads stop once buffered + in-flight words reach 2, so no read is ever dropped.
module fifo_stream_reader #(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_rd,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol
);

    // Buffer occupancy encodings.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;

    // Frame geometry must describe at least one pixel.
    if (IMG_W < 1 || IMG_H < 1) begin : g_bad_geometry
        $error("fifo_stream_reader: IMG_W and IMG_H must be at least 1");
    end

    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;   // oldest entry, drives m_data
    logic [DATA_W-1:0] buf1_q, buf1_d;   // second entry, valid only when occupancy is two
    logic              xfer;
    logic [2:0]        commit;           // slots spoken for after this edge

    assign m_valid = (occ_q != OCC_EMPTY);
    assign m_data  = buf0_q;
    assign xfer    = m_valid && m_ready;

    // Words held or in flight after this cycle; a transfer always has occupancy >= 1, so no wrap.
    always_comb begin
        commit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};
    end

    // Issue a read only when the word it returns is guaranteed a buffer slot.
    assign fifo_rd_en = !fifo_empty && (commit < 3'd2);

    // Buffer next-state: capture the returning word and shift on transfer, keeping strict FIFO order.
    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        occ_d      = commit[1:0];
        inflight_d = fifo_rd_en;
        case (occ_q)
            OCC_EMPTY: begin
                if (inflight_q) begin
                    buf0_d = fifo_data_rd;
                end
            end
            OCC_ONE: begin
                if (inflight_q) begin
                    if (xfer) begin
                        buf0_d = fifo_data_rd;
                    end else begin
                        buf1_d = fifo_data_rd;
                    end
                end
            end
            default: begin
                // Full: a capture here always coincides with a transfer.
                if (xfer) begin
                    buf0_d = buf1_q;
                    if (inflight_q) begin
                        buf1_d = fifo_data_rd;
                    end
                end
            end
        endcase
    end

    // Buffer, occupancy and in-flight registers; reset discards any buffered or pending word.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            occ_q      <= OCC_EMPTY;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef FRAME_MARKERS_EN
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Raster position of the pixel on m_data; advances only when a pixel is accepted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (xfer) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Raster position registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Tags are qualified by m_valid so they read 0 whenever no pixel is presented.
    assign m_sof = m_valid && (col_q == '0) && (row_q == '0);
    assign m_eol = m_valid && (col_q == COL_LAST);
`else
    assign m_sof = 1'b0;
    assign m_eol = 1'b0;
`endif

endmodule
